// File: rtl/vga_pos_fetch_if.sv
// BRAM read-port bundle between the position fetch engine and the block RAM.
interface vga_pos_fetch_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_rdata;

    modport master (output mem_addr, input mem_rdata);
    modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_pos_fetch.sv
// Once per frame, copies NUM_ENTRIES BRAM words into the back bank of a double-buffered
// register file and swaps banks only after the whole set has landed.
module vga_pos_fetch #(
    parameter int                    WIDTH       = 16,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    NUM_ENTRIES = 30,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 10'h100,
    parameter int                    RD_LATENCY  = 1,
    localparam int                   IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                 clk50MHz,
    input  logic                 clr,
    input  logic                 vblank,
    input  logic                 fetch_en,
    vga_pos_fetch_if.master      mem,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] SWAP  = 2'd3;

    localparam int               LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_ENTRIES);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LAT_W-1:0]      drain_q, drain_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  bank_sel_q, bank_sel_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic                  vblank_q;
    logic                  start_s;

    logic                  pv_q   [RD_LATENCY];
    logic [IDX_W-1:0]      pidx_q [RD_LATENCY];
    logic [WIDTH-1:0]      bank0_q [NUM_ENTRIES];
    logic [WIDTH-1:0]      bank1_q [NUM_ENTRIES];

    assign start_s      = vblank & ~vblank_q;
    assign mem.mem_addr = mem_addr_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;

    // Next-state logic: mem_addr always holds the index currently presented to the BRAM.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        mem_addr_d   = mem_addr_q;
        bank_sel_d   = bank_sel_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (start_s & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                mem_addr_d = BASE_ADDR;
                if (start_s && fetch_en) begin
                    state_d = FETCH;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (idx_q == IDX_LAST) begin
                    state_d    = DRAIN;
                    drain_d    = {LAT_W{1'b0}};
                    mem_addr_d = BASE_ADDR;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    mem_addr_d = BASE_ADDR + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                // Swap on the same edge that writes the final word, so SWAP shows the new frame.
                if (drain_q == LAT_LAST) begin
                    state_d      = SWAP;
                    bank_sel_d   = ~bank_sel_q;
                    frame_done_d = 1'b1;
                end else begin
                    drain_d = drain_q + LAT_W'(1);
                end
            end
            SWAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    // Control and status registers.
    always_ff @(posedge clk50MHz or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            idx_q        <= {IDX_W{1'b0}};
            drain_q      <= {LAT_W{1'b0}};
            mem_addr_q   <= BASE_ADDR;
            bank_sel_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            vblank_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            mem_addr_q   <= mem_addr_d;
            bank_sel_q   <= bank_sel_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            vblank_q     <= vblank;
        end
    end

    // Capture pipeline: the tail lines up with mem_rdata for the address it tracks.
    always_ff @(posedge clk50MHz or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pv_q[i]   <= 1'b0;
                pidx_q[i] <= {IDX_W{1'b0}};
            end
        end else begin
            pv_q[0]   <= (state_q == FETCH);
            pidx_q[0] <= idx_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i]   <= pv_q[i-1];
                pidx_q[i] <= pidx_q[i-1];
            end
        end
    end

    // Back-bank writes; the front bank is never touched while displayed.
    always_ff @(posedge clk50MHz or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                bank0_q[i] <= {WIDTH{1'b0}};
                bank1_q[i] <= {WIDTH{1'b0}};
            end
        end else if (pv_q[RD_LATENCY-1]) begin
            if (bank_sel_q) begin
                bank0_q[pidx_q[RD_LATENCY-1]] <= mem.mem_rdata;
            end else begin
                bank1_q[pidx_q[RD_LATENCY-1]] <= mem.mem_rdata;
            end
        end
    end

    // Front-bank read port.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        if ({1'b0, rd_idx} < NUM_EXT) begin
            if (bank_sel_q) begin
                rd_data = bank1_q[rd_idx];
            end else begin
                rd_data = bank0_q[rd_idx];
            end
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end
endmodule
